tia_horizontal_sync: RTL and testbench
======================================

Name: tia_horizontal_sync

Overview:
- Consumes the one-hot decodes of the horizontal LFSR decoder, plus the LFSR wrap strobe shb.
- Holds the horizontal set/reset latches: HSYNC, HBLANK (with HMOVE late-blank extension), colour burst and the WSYNC-driven RDY line.
- Also emits per-line pulses and a saturating line counter.
- Feeds the video output and CPU RDY logic; clocked by the colour clock, with hce marking the horizontal count tick.

Parameters:
- LINE_W, 9: width of line_count.

Ports:
- clk  in  1  colour clock; all state on posedge.
- rsyn_n  in  1  asynchronous active-low reset.
- hce  in  1  horizontal count enable; high one clk in four; decodes are acted on only when hce=1.
- shb  in  1  LFSR wrap / set-hblank decode (count 0).
- shs  in  1  set hsync decode (count 4).
- rhs  in  1  reset hsync decode (count 8).
- rcb  in  1  reset colour burst decode (count 12).
- rhb  in  1  reset hblank decode (count 16).
- lrhb  in  1  late reset hblank decode (count 18).
- cnt  in  1  centre decode (count 36).
- wsync  in  1  WSYNC register strobe, 1 clk.
- hmove  in  1  HMOVE register strobe, 1 clk.
- lclr  in  1  line counter clear strobe, 1 clk.
- hsync  out  1  horizontal sync.
- hblank  out  1  horizontal blank.
- cburst  out  1  colour burst gate.
- rdy  out  1  CPU ready; low while waiting for line start.
- hmove_late  out  1  HMOVE latch; selects the lrhb blank end.
- line_start  out  1  1-clk pulse per line.
- center  out  1  1-clk pulse at mid-line.
- line_count  out  LINE_W  lines since lclr, saturating.

Behaviour:
- Reset is asynchronous on rsyn_n=0. Reset values:
  - hsync=0, cburst=0, hblank=1, rdy=1, hmove_late=0
  - line_start=0, center=0, line_count=0
- Qualified decode means decode AND hce. All outputs are registered: they change on the clk edge at which the qualifying condition is sampled, so they are visible 1 clk after the inputs.
- hsync: set by qualified shs, cleared by qualified rhs. If both occur, clear wins.
- cburst: set by qualified rhs, cleared by qualified rcb. If both occur, clear wins.
- hblank:
  - set by qualified shb;
  - cleared by qualified rhb when hmove_late=0;
  - cleared by qualified lrhb when hmove_late=1.
  - While hmove_late=1, rhb is ignored. If set and clear occur together, set wins.
- hmove_late: set by hmove (any cycle, hce ignored), cleared by qualified shb. If both occur, set wins, so an HMOVE written at line start extends that line.
- rdy: cleared by wsync (any cycle), set by qualified shb. If both occur, wsync wins and rdy stays 0 until the next line.
- line_start = registered qualified shb. center = registered qualified cnt. Each is exactly 1 clk wide.
- line_count:
  - +1 on qualified shb;
  - holds at 2^LINE_W-1 (no wrap);
  - lclr forces 0 and wins over a simultaneous increment.
- Any decode with hce=0 has no effect.
- The decoder guarantees at most one of shs/rhs/rcb/rhb/lrhb/cnt per tick. The priorities above cover any overlap, including shb.
- A line is 57 ticks = 228 clk. Nominal widths:
  - hsync 4 ticks (16 clk);
  - cburst 4 ticks;
  - hblank 16 ticks (64 clk), or 18 ticks (72 clk) with HMOVE.
- Reset mid-line: all outputs return to reset values immediately. hblank stays high until the next qualified rhb/lrhb.

Test Plan:
- Reset: hold rsyn_n=0 mid-line with decodes toggling -> hsync=0, cburst=0, hblank=1, rdy=1, hmove_late=0, line_count=0 throughout. Release -> no change until the next qualified decode.
- Nominal line: drive decodes at counts 0/4/8/12/16/18/36 with hce every 4 clk, checking for two lines:
  - hsync high from count 4 to 8 (16 clk);
  - cburst high from count 8 to 12;
  - hblank falls at count 16 (64 clk after shb);
  - center and line_start are single 1-clk pulses;
  - line_count 0->1->2.
- HMOVE: pulse hmove on the same clk as qualified shb -> hmove_late=1; hblank ignores rhb and falls at count 18 (72 clk); hmove_late clears at the next shb. Pulse hmove mid-line -> hblank of the current line is unaffected if rhb has already passed.
- WSYNC: pulse wsync at count 30 -> rdy=0 next clk, rdy=1 one clk after the next qualified shb. Pulse wsync on the qualified-shb clk -> rdy stays 0 for the full following line (228 clk).
- hce gating: assert shs/shb with hce=0 -> no output changes.
- Line counter with LINE_W=3: run 9 lines -> count saturates at 7. Assert lclr together with qualified shb -> 0.

Source files
------------

// File: rtl/tia_horizontal_sync.sv
// Horizontal sync/blank/burst/RDY latches driven by the qualified horizontal LFSR decodes.
// Latency: every output is registered, 1 clk after the decode. There is no backpressure.
module tia_horizontal_sync #(
   parameter int LINE_W = 9
) (
   input  logic              clk,
   input  logic              rsyn_n,
   input  logic              hce,
   input  logic              shb,
   input  logic              shs,
   input  logic              rhs,
   input  logic              rcb,
   input  logic              rhb,
   input  logic              lrhb,
   input  logic              cnt,
   input  logic              wsync,
   input  logic              hmove,
   input  logic              lclr,
   output logic              hsync,
   output logic              hblank,
   output logic              cburst,
   output logic              rdy,
   output logic              hmove_late,
   output logic              line_start,
   output logic              center,
   output logic [LINE_W-1:0] line_count
);

   localparam logic [LINE_W-1:0] CNT_MAX = '1;
   localparam logic [LINE_W-1:0] CNT_ONE = {{(LINE_W-1){1'b0}}, 1'b1};

   logic              hsync_q, hsync_d;
   logic              hblank_q, hblank_d;
   logic              cburst_q, cburst_d;
   logic              rdy_q, rdy_d;
   logic              hmove_late_q, hmove_late_d;
   logic              line_start_q, line_start_d;
   logic              center_q, center_d;
   logic [LINE_W-1:0] line_count_q, line_count_d;

   logic q_shb, q_shs, q_rhs, q_rcb, q_rhb, q_lrhb, q_cnt;
   logic hblank_clr;

   assign q_shb  = shb  & hce;
   assign q_shs  = shs  & hce;
   assign q_rhs  = rhs  & hce;
   assign q_rcb  = rcb  & hce;
   assign q_rhb  = rhb  & hce;
   assign q_lrhb = lrhb & hce;
   assign q_cnt  = cnt  & hce;

   // An HMOVE this line moves the blank end from rhb to the later lrhb decode.
   assign hblank_clr = hmove_late_q ? q_lrhb : q_rhb;

   always_comb begin
      hsync_d      = hsync_q;
      hblank_d     = hblank_q;
      cburst_d     = cburst_q;
      rdy_d        = rdy_q;
      hmove_late_d = hmove_late_q;
      line_start_d = q_shb;
      center_d     = q_cnt;
      line_count_d = line_count_q;

      if (q_rhs)           hsync_d = 1'b0;
      else if (q_shs)      hsync_d = 1'b1;

      if (q_rcb)           cburst_d = 1'b0;
      else if (q_rhs)      cburst_d = 1'b1;

      if (q_shb)           hblank_d = 1'b1;
      else if (hblank_clr) hblank_d = 1'b0;

      if (hmove)           hmove_late_d = 1'b1;
      else if (q_shb)      hmove_late_d = 1'b0;

      if (wsync)           rdy_d = 1'b0;
      else if (q_shb)      rdy_d = 1'b1;

      if (lclr)                                line_count_d = '0;
      else if (q_shb && line_count_q != CNT_MAX) line_count_d = line_count_q + CNT_ONE;
   end

   always_ff @(posedge clk or negedge rsyn_n) begin
      if (!rsyn_n) begin
         hsync_q      <= 1'b0;
         hblank_q     <= 1'b1;
         cburst_q     <= 1'b0;
         rdy_q        <= 1'b1;
         hmove_late_q <= 1'b0;
         line_start_q <= 1'b0;
         center_q     <= 1'b0;
         line_count_q <= '0;
      end else begin
         hsync_q      <= hsync_d;
         hblank_q     <= hblank_d;
         cburst_q     <= cburst_d;
         rdy_q        <= rdy_d;
         hmove_late_q <= hmove_late_d;
         line_start_q <= line_start_d;
         center_q     <= center_d;
         line_count_q <= line_count_d;
      end
   end

   assign hsync      = hsync_q;
   assign hblank     = hblank_q;
   assign cburst     = cburst_q;
   assign rdy        = rdy_q;
   assign hmove_late = hmove_late_q;
   assign line_start = line_start_q;
   assign center     = center_q;
   assign line_count = line_count_q;

endmodule

// File: tb/tb_tia_horizontal_sync.sv
// Directed bench for tia_horizontal_sync with a 3-bit line counter.
module tb_tia_horizontal_sync;

   localparam int LINE_W = 3;

   logic clk = 1'b0;
   logic rsyn_n = 1'b0;
   logic hce = 1'b0, shb = 1'b0, shs = 1'b0, rhs = 1'b0, rcb = 1'b0;
   logic rhb = 1'b0, lrhb = 1'b0, cnt = 1'b0, wsync = 1'b0, hmove = 1'b0, lclr = 1'b0;
   logic hsync, hblank, cburst, rdy, hmove_late, line_start, center;
   logic [LINE_W-1:0] line_count;

   int checks = 0;
   int errors = 0;

   // Per-line observations, indexed from the shb clk of the line.
   int clk_idx, hb_fall, n_hs, n_cb, n_ls, n_ce, n_hml, n_rdylo;
   int lc_exp = 0;

   localparam logic [9:0] RESET_VEC = {7'b0011000, 3'd0};

   tia_horizontal_sync #(.LINE_W(LINE_W)) dut (
      .clk        (clk),
      .rsyn_n     (rsyn_n),
      .hce        (hce),
      .shb        (shb),
      .shs        (shs),
      .rhs        (rhs),
      .rcb        (rcb),
      .rhb        (rhb),
      .lrhb       (lrhb),
      .cnt        (cnt),
      .wsync      (wsync),
      .hmove      (hmove),
      .lclr       (lclr),
      .hsync      (hsync),
      .hblank     (hblank),
      .cburst     (cburst),
      .rdy        (rdy),
      .hmove_late (hmove_late),
      .line_start (line_start),
      .center     (center),
      .line_count (line_count)
   );

   always #5 clk = ~clk;

   function automatic logic [9:0] outs();
      return {hsync, cburst, hblank, rdy, hmove_late, line_start, center, line_count};
   endfunction

   // Decode bits: {cnt, lrhb, rhb, rcb, rhs, shs, shb}
   function automatic logic [6:0] dec_for(input int c);
      case (c)
         0:       return 7'h01;
         4:       return 7'h02;
         8:       return 7'h04;
         12:      return 7'h08;
         16:      return 7'h10;
         18:      return 7'h20;
         36:      return 7'h40;
         default: return 7'h00;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic do_clk(input logic h, input logic [6:0] dec, input logic ws,
                         input logic hm, input logic lc);
      hce = h;
      {cnt, lrhb, rhb, rcb, rhs, shs, shb} = dec;
      wsync = ws; hmove = hm; lclr = lc;
      @(posedge clk);
      #1;
      hce = 1'b0;
      {cnt, lrhb, rhb, rcb, rhs, shs, shb} = 7'h00;
      wsync = 1'b0; hmove = 1'b0; lclr = 1'b0;
      if (hsync === 1'b1)      n_hs++;
      if (cburst === 1'b1)     n_cb++;
      if (line_start === 1'b1) n_ls++;
      if (center === 1'b1)     n_ce++;
      if (hmove_late === 1'b1) n_hml++;
      if (rdy === 1'b0)        n_rdylo++;
      if (hblank === 1'b0 && hb_fall < 0) hb_fall = clk_idx;
      clk_idx++;
   endtask

   task automatic run_line(input int hm_at, input int ws_at, input logic lc0);
      clk_idx = 0; hb_fall = -1;
      n_hs = 0; n_cb = 0; n_ls = 0; n_ce = 0; n_hml = 0; n_rdylo = 0;
      for (int t = 0; t < 57; t++) begin
         do_clk(1'b1, dec_for(t), ws_at == t, hm_at == t, lc0 && t == 0);
         for (int k = 0; k < 3; k++) do_clk(1'b0, 7'h00, 1'b0, 1'b0, 1'b0);
      end
      lc_exp = lc0 ? 0 : ((lc_exp == 7) ? 7 : lc_exp + 1);
   endtask

   task automatic check_line(input string tag, input int hbf, input int hml, input int rlo);
      chk({tag, ".hsync_clks"}, n_hs, 16);
      chk({tag, ".cburst_clks"}, n_cb, 16);
      chk({tag, ".line_start_clks"}, n_ls, 1);
      chk({tag, ".center_clks"}, n_ce, 1);
      chk({tag, ".hblank_fall"}, hb_fall, hbf);
      chk({tag, ".hmove_late_clks"}, n_hml, hml);
      chk({tag, ".rdy_low_clks"}, n_rdylo, rlo);
      chk({tag, ".line_count"}, line_count, lc_exp);
   endtask

   initial begin
      // Decodes and strobes toggling while reset is held.
      for (int i = 0; i < 12; i++) begin
         do_clk(1'b1, 7'h7f, i[0], ~i[0], i[1]);
         chk("reset_hold", outs(), RESET_VEC);
      end
      rsyn_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         do_clk(1'b0, 7'h00, 1'b0, 1'b0, 1'b0);
         chk("reset_release", outs(), RESET_VEC);
      end

      run_line(-1, -1, 1'b0); check_line("nom1", 64, 0, 0);
      run_line(-1, -1, 1'b0); check_line("nom2", 64, 0, 0);
      run_line(0, -1, 1'b0);  check_line("hmove_shb", 72, 228, 0);
      run_line(-1, -1, 1'b0); check_line("after_hmove", 64, 0, 0);
      run_line(30, -1, 1'b0); check_line("hmove_mid", 64, 108, 0);
      run_line(-1, -1, 1'b0); check_line("after_hmove_mid", 64, 0, 0);
      run_line(-1, 30, 1'b0); check_line("wsync30", 64, 0, 108);
      run_line(-1, -1, 1'b0); check_line("after_wsync30", 64, 0, 0);
      run_line(-1, 0, 1'b0);  check_line("wsync_shb", 64, 0, 228);
      run_line(-1, -1, 1'b0); check_line("after_wsync_shb", 64, 0, 0);
      run_line(-1, -1, 1'b1); check_line("lclr_shb", 64, 0, 0);
      run_line(-1, -1, 1'b0); check_line("after_lclr", 64, 0, 0);

      // Decodes without hce must leave everything alone.
      for (int i = 0; i < 4; i++) begin
         do_clk(1'b0, 7'h7f, 1'b0, 1'b0, 1'b0);
         chk("hce_gate", outs(), {7'b0001000, 3'd1});
      end

      do_clk(1'b0, 7'h00, 1'b0, 1'b0, 1'b1);
      chk("lclr_alone", line_count, 0);

      // Reset in the middle of a line with hsync, hmove_late and wsync active.
      do_clk(1'b1, dec_for(0), 1'b1, 1'b1, 1'b0);
      for (int t = 1; t < 5; t++) begin
         for (int k = 0; k < 3; k++) do_clk(1'b0, 7'h00, 1'b0, 1'b0, 1'b0);
         do_clk(1'b1, dec_for(t), 1'b0, 1'b0, 1'b0);
      end
      chk("pre_reset", outs(), {7'b1010100, 3'd1});
      rsyn_n = 1'b0;
      #1;
      chk("midline_reset", outs(), RESET_VEC);
      #2 rsyn_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         do_clk(1'b0, 7'h00, 1'b0, 1'b0, 1'b0);
         chk("post_reset_idle", outs(), RESET_VEC);
      end
      do_clk(1'b1, dec_for(16), 1'b0, 1'b0, 1'b0);
      chk("post_reset_rhb", hblank, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
